// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/memory-stage requesters, the arbiter and the 16-bit SRAM.
// The arbiter connects through the slave modport; requesters and the SRAM model use master.
interface ram_arbiter_if;
    logic        if_req;
    logic [17:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_rw;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout;
    logic        ram_doe;
    logic [15:0] ram_din;
    logic        ram_wre;
    logic        busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_din,
        output if_rdata, if_ack, mem_rdata, mem_ack,
               ram_addr, ram_dout, ram_doe, ram_wre, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_din,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
               ram_addr, ram_dout, ram_doe, ram_wre, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter that turns 32-bit fetch/memory-stage accesses into two
// 16-bit asynchronous SRAM cycles (even halfword first), with fully registered outputs.
module ram_arbiter #(
    parameter int MEM_PRIORITY = 1
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

    state_t      state_q, state_d;
    logic [16:0] wordAddr_q, wordAddr_d;
    logic        isWrite_q, isWrite_d;
    logic        grantMem_q, grantMem_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] loHalf_q, loHalf_d;
    logic [17:0] ramAddr_q, ramAddr_d;
    logic [15:0] ramDout_q, ramDout_d;
    logic        ramDoe_q, ramDoe_d;
    logic        ramWre_q, ramWre_d;
    logic        ifAck_q, ifAck_d;
    logic        memAck_q, memAck_d;
    logic [31:0] ifRdata_q, ifRdata_d;
    logic [31:0] memRdata_q, memRdata_d;
    logic        busy_q, busy_d;

    logic        pickMem;
    logic [16:0] reqWordAddr;
    logic        reqWrite;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            wordAddr_q <= '0;
            isWrite_q  <= 1'b0;
            grantMem_q <= 1'b0;
            wdata_q    <= '0;
            loHalf_q   <= '0;
            ramAddr_q  <= '0;
            ramDout_q  <= '0;
            ramDoe_q   <= 1'b0;
            ramWre_q   <= 1'b1;
            ifAck_q    <= 1'b0;
            memAck_q   <= 1'b0;
            ifRdata_q  <= '0;
            memRdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wordAddr_q <= wordAddr_d;
            isWrite_q  <= isWrite_d;
            grantMem_q <= grantMem_d;
            wdata_q    <= wdata_d;
            loHalf_q   <= loHalf_d;
            ramAddr_q  <= ramAddr_d;
            ramDout_q  <= ramDout_d;
            ramDoe_q   <= ramDoe_d;
            ramWre_q   <= ramWre_d;
            ifAck_q    <= ifAck_d;
            memAck_q   <= memAck_d;
            ifRdata_q  <= ifRdata_d;
            memRdata_q <= memRdata_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs are computed one state ahead so that each registered value lines up with its state.
    always_comb begin
        state_d    = state_q;
        wordAddr_d = wordAddr_q;
        isWrite_d  = isWrite_q;
        grantMem_d = grantMem_q;
        wdata_d    = wdata_q;
        loHalf_d   = loHalf_q;
        ramAddr_d  = ramAddr_q;
        ramDout_d  = ramDout_q;
        ramDoe_d   = 1'b0;
        ramWre_d   = 1'b1;
        ifAck_d    = 1'b0;
        memAck_d   = 1'b0;
        ifRdata_d  = ifRdata_q;
        memRdata_d = memRdata_q;

        pickMem     = bus.mem_req && (!bus.if_req || (MEM_PRIORITY != 0));
        reqWordAddr = pickMem ? bus.mem_addr[17:1] : bus.if_addr[17:1];
        reqWrite    = pickMem && bus.mem_rw;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    state_d    = LO;
                    grantMem_d = pickMem;
                    wordAddr_d = reqWordAddr;
                    isWrite_d  = reqWrite;
                    wdata_d    = bus.mem_wdata;
                    ramAddr_d  = {reqWordAddr, 1'b0};
                    ramWre_d   = !reqWrite;
                    ramDoe_d   = reqWrite;
                    if (reqWrite) begin
                        ramDout_d = bus.mem_wdata[15:0];
                    end
                end
            end
            LO: begin
                state_d   = HI;
                loHalf_d  = bus.ram_din;
                ramAddr_d = {wordAddr_q, 1'b1};
                ramWre_d  = !isWrite_q;
                ramDoe_d  = isWrite_q;
                if (isWrite_q) begin
                    ramDout_d = wdata_q[31:16];
                end
            end
            HI: begin
                state_d = ACK;
                if (grantMem_q) begin
                    memAck_d = 1'b1;
                    if (!isWrite_q) begin
                        memRdata_d = {bus.ram_din, loHalf_q};
                    end
                end else begin
                    ifAck_d   = 1'b1;
                    ifRdata_d = {bus.ram_din, loHalf_q};
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.if_rdata  = ifRdata_q;
    assign bus.if_ack    = ifAck_q;
    assign bus.mem_rdata = memRdata_q;
    assign bus.mem_ack   = memAck_q;
    assign bus.ram_addr  = ramAddr_q;
    assign bus.ram_dout  = ramDout_q;
    assign bus.ram_doe   = ramDoe_q;
    assign bus.ram_wre   = ramWre_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance per arbitration priority, each with a
// small behavioural asynchronous SRAM on its halfword bus.
module tb_ram_arbiter;

    logic clock;
    logic reset;

    ram_arbiter_if bus1 ();
    ram_arbiter_if bus0 ();

    ram_arbiter #(.MEM_PRIORITY(1)) dutMem (.clock(clock), .reset(reset), .bus(bus1));
    ram_arbiter #(.MEM_PRIORITY(0)) dutFetch (.clock(clock), .reset(reset), .bus(bus0));

    logic [15:0] sram1 [0:255];
    logic [15:0] sram0 [0:255];
    logic        preloadEn;
    logic [7:0]  preloadAddr;
    logic [15:0] preloadData;

    int checkCount = 0;
    int errorCount = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Asynchronous read, write committed at the edge that ends a write cycle.
    assign bus1.ram_din = sram1[bus1.ram_addr[7:0]];
    assign bus0.ram_din = sram0[bus0.ram_addr[7:0]];

    always @(posedge clock) begin
        if (preloadEn) begin
            sram1[preloadAddr] <= preloadData;
            sram0[preloadAddr] <= preloadData;
        end else begin
            if (!bus1.ram_wre && bus1.ram_doe) sram1[bus1.ram_addr[7:0]] <= bus1.ram_dout;
            if (!bus0.ram_wre && bus0.ram_doe) sram0[bus0.ram_addr[7:0]] <= bus0.ram_dout;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [17:0] ifAddr,
                                 input logic memReq, input logic memRw,
                                 input logic [17:0] memAddr, input logic [31:0] memWdata);
        bus1.if_req    = ifReq;
        bus1.if_addr   = ifAddr;
        bus1.mem_req   = memReq;
        bus1.mem_rw    = memRw;
        bus1.mem_addr  = memAddr;
        bus1.mem_wdata = memWdata;
    endtask

    task automatic loadHalf(input logic [7:0] addr, input logic [15:0] data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        tick();
        preloadEn = 1'b0;
    endtask

    initial begin
        logic [7:0] busyPattern;
        logic [7:0] ackPattern;

        reset = 1'b0;
        preloadEn = 1'b0;
        preloadAddr = '0;
        preloadData = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.mem_req = 1'b0;
        bus0.mem_rw = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
        tick();
        tick();

        checkOutput("rstIfAck", {31'd0, bus1.if_ack}, 32'd0);
        checkOutput("rstMemAck", {31'd0, bus1.mem_ack}, 32'd0);
        checkOutput("rstBusy", {31'd0, bus1.busy}, 32'd0);
        checkOutput("rstWre", {31'd0, bus1.ram_wre}, 32'd1);
        checkOutput("rstDoe", {31'd0, bus1.ram_doe}, 32'd0);
        checkOutput("rstRamAddr", {14'd0, bus1.ram_addr}, 32'd0);
        checkOutput("rstRamDout", {16'd0, bus1.ram_dout}, 32'd0);
        checkOutput("rstIfRdata", bus1.if_rdata, 32'd0);
        checkOutput("rstMemRdata", bus1.mem_rdata, 32'd0);
        checkOutput("rstWre0", {31'd0, bus0.ram_wre}, 32'd1);

        loadHalf(8'h10, 16'h5678);
        loadHalf(8'h11, 16'h1234);
        loadHalf(8'h40, 16'hCAFE);
        loadHalf(8'h41, 16'hF00D);
        reset = 1'b1;
        tick();

        // Fetch read of the word at halfword 0x10.
        applyStimulus(1'b1, 18'h10, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("fetchLoAddr", {14'd0, bus1.ram_addr}, 32'h10);
        checkOutput("fetchLoBusy", {31'd0, bus1.busy}, 32'd1);
        checkOutput("fetchLoWre", {31'd0, bus1.ram_wre}, 32'd1);
        checkOutput("fetchLoDoe", {31'd0, bus1.ram_doe}, 32'd0);
        tick();
        checkOutput("fetchHiAddr", {14'd0, bus1.ram_addr}, 32'h11);
        checkOutput("fetchHiAck", {31'd0, bus1.if_ack}, 32'd0);
        tick();
        checkOutput("fetchAck", {31'd0, bus1.if_ack}, 32'd1);
        checkOutput("fetchRdata", bus1.if_rdata, 32'h12345678);
        checkOutput("fetchNoMemAck", {31'd0, bus1.mem_ack}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("fetchAckDrop", {31'd0, bus1.if_ack}, 32'd0);
        checkOutput("fetchRdataHold", bus1.if_rdata, 32'h12345678);
        checkOutput("fetchIdleBusy", {31'd0, bus1.busy}, 32'd0);
        checkOutput("fetchAddrHold", {14'd0, bus1.ram_addr}, 32'h11);

        // Memory write to an odd address; inputs change during LO.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 18'h21, 32'hDEADBEEF);
        tick();
        checkOutput("wrLoAddr", {14'd0, bus1.ram_addr}, 32'h20);
        checkOutput("wrLoWre", {31'd0, bus1.ram_wre}, 32'd0);
        checkOutput("wrLoDoe", {31'd0, bus1.ram_doe}, 32'd1);
        checkOutput("wrLoDout", {16'd0, bus1.ram_dout}, 32'hBEEF);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 18'h3A, 32'h0);
        tick();
        checkOutput("wrHiAddr", {14'd0, bus1.ram_addr}, 32'h21);
        checkOutput("wrHiDout", {16'd0, bus1.ram_dout}, 32'hDEAD);
        checkOutput("wrHiWre", {31'd0, bus1.ram_wre}, 32'd0);
        tick();
        checkOutput("wrMemAck", {31'd0, bus1.mem_ack}, 32'd1);
        checkOutput("wrNoIfAck", {31'd0, bus1.if_ack}, 32'd0);
        checkOutput("wrAckWre", {31'd0, bus1.ram_wre}, 32'd1);
        checkOutput("wrAckDoe", {31'd0, bus1.ram_doe}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("wrAckDrop", {31'd0, bus1.mem_ack}, 32'd0);
        checkOutput("wrSramLo", {16'd0, sram1[8'h20]}, 32'hBEEF);
        checkOutput("wrSramHi", {16'd0, sram1[8'h21]}, 32'hDEAD);

        // Simultaneous requests, memory stage has priority.
        applyStimulus(1'b1, 18'h40, 1'b1, 1'b0, 18'h20, '0);
        tick();
        checkOutput("prio1FirstAddr", {14'd0, bus1.ram_addr}, 32'h20);
        tick();
        tick();
        checkOutput("prio1MemAck", {31'd0, bus1.mem_ack}, 32'd1);
        checkOutput("prio1MemRdata", bus1.mem_rdata, 32'hDEADBEEF);
        checkOutput("prio1IfWait", {31'd0, bus1.if_ack}, 32'd0);
        applyStimulus(1'b1, 18'h40, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("prio1GapBusy", {31'd0, bus1.busy}, 32'd0);
        tick();
        checkOutput("prio1SecondAddr", {14'd0, bus1.ram_addr}, 32'h40);
        tick();
        tick();
        checkOutput("prio1IfAck", {31'd0, bus1.if_ack}, 32'd1);
        checkOutput("prio1IfRdata", bus1.if_rdata, 32'hF00DCAFE);
        checkOutput("prio1MemRdataHold", bus1.mem_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        // Request held across ack starts a second transaction after one IDLE cycle.
        busyPattern = 8'b1110_1110;
        ackPattern  = 8'b1000_1000;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 18'h10, '0);
        checkOutput("holdBusy0", {31'd0, bus1.busy}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput($sformatf("holdBusy%0d", i), {31'd0, bus1.busy}, {31'd0, busyPattern[i]});
            checkOutput($sformatf("holdAck%0d", i), {31'd0, bus1.mem_ack}, {31'd0, ackPattern[i]});
            if (ackPattern[i]) begin
                checkOutput($sformatf("holdRdata%0d", i), bus1.mem_rdata, 32'h12345678);
            end
            if (i == 7) begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
            end
        end
        tick();

        // Reset in the HI cycle of a write aborts it.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 18'h30, 32'h11112222);
        tick();
        tick();
        checkOutput("abortHiWre", {31'd0, bus1.ram_wre}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("abortMemAck", {31'd0, bus1.mem_ack}, 32'd0);
        checkOutput("abortWre", {31'd0, bus1.ram_wre}, 32'd1);
        checkOutput("abortBusy", {31'd0, bus1.busy}, 32'd0);
        checkOutput("abortDoe", {31'd0, bus1.ram_doe}, 32'd0);
        checkOutput("abortRamAddr", {14'd0, bus1.ram_addr}, 32'd0);
        checkOutput("abortRamDout", {16'd0, bus1.ram_dout}, 32'd0);
        checkOutput("abortIfRdata", bus1.if_rdata, 32'd0);
        checkOutput("abortMemRdata", bus1.mem_rdata, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        checkOutput("abortAfterAck", {31'd0, bus1.mem_ack}, 32'd0);
        checkOutput("abortAfterBusy", {31'd0, bus1.busy}, 32'd0);

        // Simultaneous requests, fetch has priority.
        bus0.if_req = 1'b1; bus0.if_addr = 18'h10;
        bus0.mem_req = 1'b1; bus0.mem_rw = 1'b0; bus0.mem_addr = 18'h40;
        tick();
        checkOutput("prio0FirstAddr", {14'd0, bus0.ram_addr}, 32'h10);
        tick();
        tick();
        checkOutput("prio0IfAck", {31'd0, bus0.if_ack}, 32'd1);
        checkOutput("prio0IfRdata", bus0.if_rdata, 32'h12345678);
        checkOutput("prio0MemWait", {31'd0, bus0.mem_ack}, 32'd0);
        bus0.if_req = 1'b0;
        tick();
        checkOutput("prio0GapBusy", {31'd0, bus0.busy}, 32'd0);
        tick();
        checkOutput("prio0SecondAddr", {14'd0, bus0.ram_addr}, 32'h40);
        tick();
        tick();
        checkOutput("prio0MemAck", {31'd0, bus0.mem_ack}, 32'd1);
        checkOutput("prio0MemRdata", bus0.mem_rdata, 32'hF00DCAFE);
        checkOutput("prio0IfRdataHold", bus0.if_rdata, 32'h12345678);
        bus0.mem_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
